// File: rtl/game_score_bcd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : game_score_bcd_decoder (with package score_pkg)
// Description : Converts NUM_CH binary game scores to decimal glyphs using a
//               single shared, sequential double-dabble converter. Channels
//               are converted one after another; each channel's digits are
//               updated atomically on its WRITE cycle.
// Option      : SCORE_BLANK_LZ_EN - blank leading zeros above digit 0.
// Revision    : 1.0 - initial release
// ============================================================================

package score_pkg;
    // Glyph codes; the all-zeros code is the blank glyph
    typedef enum logic [3:0] {
        BLANK = 4'd0,
        ZERO  = 4'd1,
        ONE   = 4'd2,
        TWO   = 4'd3,
        THREE = 4'd4,
        FOUR  = 4'd5,
        FIVE  = 4'd6,
        SIX   = 4'd7,
        SEVEN = 4'd8,
        EIGHT = 4'd9,
        NEIN  = 4'd10
    } score_t;
endpackage

module game_score_bcd_decoder
    import score_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int SCORE_W    = 7,
    parameter int NUM_DIGITS = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [NUM_CH-1:0][SCORE_W-1:0]     score_i,
    output logic                               busy_o,
    output logic                               done_o,
    output score_t [NUM_CH-1:0][NUM_DIGITS-1:0] digits_o,
    output logic [NUM_CH-1:0]                  sat_o
);

    // Decimal digits needed for the largest SCORE_W-bit value
    function automatic int calc_nib(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int BIN_NIB = calc_nib(SCORE_W);
    localparam int ACC_NIB = (BIN_NIB > NUM_DIGITS) ? BIN_NIB : NUM_DIGITS;
    localparam int ACC_W   = 4 * ACC_NIB;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_next_state;
    logic [NUM_CH-1:0][SCORE_W-1:0]   r_snap;
    logic [CH_W-1:0]                  r_ch;
    logic [CNT_W-1:0]                 r_cnt;
    logic [SCORE_W-1:0]               r_shreg;
    logic [ACC_W-1:0]                 r_acc;
    logic [ACC_W-1:0]                 w_acc_corr;
    logic                             r_pending;
    logic                             w_load;
    logic                             w_shift;
    logic                             w_write;
    logic                             w_next_ch;
    logic                             w_final;
    logic                             w_sat;
    score_t [NUM_DIGITS-1:0]          w_glyphs;

    // BCD nibble to glyph; corrected nibbles never exceed 9
    function automatic score_t nib_to_glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    return ZERO;
            4'd1:    return ONE;
            4'd2:    return TWO;
            4'd3:    return THREE;
            4'd4:    return FOUR;
            4'd5:    return FIVE;
            4'd6:    return SIX;
            4'd7:    return SEVEN;
            4'd8:    return EIGHT;
            4'd9:    return NEIN;
            default: return ZERO;
        endcase
    endfunction

    assign busy_o = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_write      = 1'b0;
        w_next_ch    = 1'b0;
        w_final      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_write = 1'b1;
                if (r_ch != LAST_CH) begin
                    w_next_ch    = 1'b1;
                    w_next_state = ST_SHIFT;
                end else begin
                    w_final = 1'b1;
                    // A request arriving on the final WRITE itself also restarts
                    if (r_pending || start_i) begin
                        w_load       = 1'b1;
                        w_next_state = ST_SHIFT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Add-3 correction of every nibble that is 5 or more before the shift
    always_comb begin
        w_acc_corr = r_acc;
        for (int i = 0; i < ACC_NIB; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_corr[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Saturation detect and glyph mapping of the finished accumulator
    always_comb begin
`ifdef SCORE_BLANK_LZ_EN
        logic lz;
        lz = 1'b1;
`endif
        w_sat = 1'b0;
        for (int i = NUM_DIGITS; i < ACC_NIB; i++) begin
            w_sat = w_sat | (r_acc[4*i +: 4] != 4'd0);
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_glyphs[i] = nib_to_glyph(r_acc[4*i +: 4]);
`ifdef SCORE_BLANK_LZ_EN
            lz = lz & (r_acc[4*i +: 4] == 4'd0);
            if (lz && (i != 0)) begin
                w_glyphs[i] = BLANK;
            end
`endif
            if (w_sat) begin
                w_glyphs[i] = NEIN;
            end
        end
    end

    // Snapshot, shift/accumulate, pending request and channel output update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snap    <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_acc     <= '0;
            r_pending <= 1'b0;
            done_o    <= 1'b0;
            sat_o     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
`ifdef SCORE_BLANK_LZ_EN
                    digits_o[c][d] <= (d == 0) ? ZERO : BLANK;
`else
                    digits_o[c][d] <= ZERO;
`endif
                end
            end
        end else begin
            if (w_load) begin
                r_snap  <= score_i;
                r_ch    <= '0;
                r_cnt   <= '0;
                r_shreg <= score_i[0];
                r_acc   <= '0;
            end else if (w_next_ch) begin
                r_ch    <= r_ch + CH_W'(1);
                r_cnt   <= '0;
                r_shreg <= r_snap[r_ch + CH_W'(1)];
                r_acc   <= '0;
            end else if (w_shift) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shreg <= r_shreg << 1;
                r_acc   <= {w_acc_corr[ACC_W-2:0], r_shreg[SCORE_W-1]};
            end

            if (w_load) begin
                r_pending <= 1'b0;
            end else if (busy_o && start_i) begin
                r_pending <= 1'b1;
            end

            if (w_write) begin
                digits_o[r_ch] <= w_glyphs;
                sat_o[r_ch]    <= w_sat;
            end

            done_o <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_score_bcd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_score_bcd_decoder
// Description : Self-checking bench for game_score_bcd_decoder (defaults).
//               Honours SCORE_BLANK_LZ_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_score_bcd_decoder;
    import score_pkg::*;

    localparam int MAXV = 99;
`ifdef SCORE_BLANK_LZ_EN
    localparam logic [3:0] LZ = BLANK;
`else
    localparam logic [3:0] LZ = ZERO;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [1:0][6:0]       score;
    logic                  busy;
    logic                  done;
    score_t [1:0][1:0]     digits;
    logic [1:0]            sat;

    int tests = 0;
    int fails = 0;

    game_score_bcd_decoder #(
        .NUM_CH    (2),
        .SCORE_W   (7),
        .NUM_DIGITS(2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .score_i (score),
        .busy_o  (busy),
        .done_o  (done),
        .digits_o(digits),
        .sat_o   (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [1:0] esat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Decimal model of one displayed digit
    function automatic logic [3:0] exp_glyph(input int v, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (v > MAXV) return NEIN;
`ifdef SCORE_BLANK_LZ_EN
        if (d > 0 && v < p) return BLANK;
`endif
        return 4'((v / p) % 10 + 1);
    endfunction

    task automatic pulse_start(input int a, input int b);
        @(negedge clk);
        score[0] = 7'(a);
        score[1] = 7'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 60);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_model(input string nm, input int a, input int b);
        logic [7:0] e0, e1;
        e0 = {exp_glyph(a, 1), exp_glyph(a, 0)};
        e1 = {exp_glyph(b, 1), exp_glyph(b, 0)};
        chk($sformatf("%s_ch0(%0d)", nm, a), {24'd0, digits[0]}, {24'd0, e0});
        chk($sformatf("%s_ch1(%0d)", nm, b), {24'd0, digits[1]}, {24'd0, e1});
        chk($sformatf("%s_sat(%0d,%0d)", nm, a, b), {30'd0, sat},
            {30'd0, (b > MAXV), (a > MAXV)});
    endtask

    task automatic run_model(input string nm, input int a, input int b);
        int lat;
        pulse_start(a, b);
        wait_done(lat);
        chk({nm, "_latency"}, lat, 32'd16);
        check_model(nm, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, d1, d2;

        vecs[0] = '{7'd7,  7'd42,  {LZ, SEVEN},  {FOUR, TWO},   2'b00};
        vecs[1] = '{7'd99, 7'd100, {NEIN, NEIN}, {NEIN, NEIN},  2'b10};
        vecs[2] = '{7'd5,  7'd0,   {LZ, FIVE},   {LZ, ZERO},    2'b00};
        vecs[3] = '{7'd0,  7'd90,  {LZ, ZERO},   {NEIN, ZERO},  2'b00};
        vecs[4] = '{7'd19, 7'd60,  {ONE, NEIN},  {SIX, ZERO},   2'b00};
        vecs[5] = '{7'd10, 7'd127, {ONE, ZERO},  {NEIN, NEIN},  2'b10};

        rst_n = 1'b0;
        start = 1'b0;
        score = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sat", {30'd0, sat}, 32'd0);
        chk("reset_digits", {16'd0, digits}, {16'd0, LZ, ZERO, LZ, ZERO});
        rst_n = 1'b1;

        // Table vectors with full timing checks
        for (int i = 0; i < 6; i++) begin
            pulse_start(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_start", i), {31'd0, busy}, 32'd1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd16);
            chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_ch0", i), {24'd0, digits[0]}, {24'd0, vecs[i].e0});
            chk($sformatf("v%0d_ch1", i), {24'd0, digits[1]}, {24'd0, vecs[i].e1});
            chk($sformatf("v%0d_sat", i), {30'd0, sat}, {30'd0, vecs[i].esat});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Asynchronous reset in the middle of SHIFT
        pulse_start(33, 8);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_sat", {30'd0, sat}, 32'd0);
        chk("arst_digits", {16'd0, digits}, {16'd0, LZ, ZERO, LZ, ZERO});
        @(negedge clk);
        rst_n = 1'b1;
        run_model("post_reset", 33, 8);

        // Second request during a sequence: pending restart with a fresh snapshot
        pulse_start(3, 0);
        repeat (4) @(negedge clk);
        score[0] = 7'd4;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        d1 = -1;
        d2 = -1;
        for (int k = 6; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("pend_first_ch0", {24'd0, digits[0]}, {24'd0, LZ, THREE});
                    chk("pend_first_busy", {31'd0, busy}, 32'd1);
                end else if (d2 < 0) begin
                    d2 = k;
                    chk("pend_second_ch0", {24'd0, digits[0]}, {24'd0, LZ, FOUR});
                    chk("pend_second_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
        chk("pend_first_time", d1, 32'd16);
        chk("pend_second_time", d2, 32'd32);

        // Score toggling during the sequence is ignored
        pulse_start(55, 81);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            score = 14'($urandom);
        end while (!done && lat < 60);
        chk("toggle_latency", lat, 32'd16);
        check_model("toggle", 55, 81);

        // Sweep every score on both channels
        for (int v = 0; v < 128; v++) begin
            run_model("sweep", v, 127 - v);
        end

        // Random pairs
        for (int n = 0; n < 30; n++) begin
            run_model("rand", int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_score_bcd_decoder.md
# game_score_bcd_decoder

Multi-digit, multi-channel score-to-glyph decoder for the pong score overlay. It converts each channel's binary score to decimal with a single shared sequential double-dabble converter, then maps every decimal digit to a `score_t` glyph from `score_pkg`. It sits between the game-logic score counters and the score renderer and supports scores above 9, which the single-digit path cannot display.

## Interface
- `NUM_CH`, default 2: number of score channels (0 = player, 1 = enemy).
- `SCORE_W`, default 7: binary score width per channel.
- `NUM_DIGITS`, default 2: decimal digits per channel (1..4).
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. One clock; reset is asynchronous and active-low.
- `start_i`  in  1: one-cycle request to convert all channels.
- `score_i`  in  NUM_CH x SCORE_W: binary scores, unsigned.
- `busy_o`  out  1: a conversion sequence is in progress.
- `done_o`  out  1: one-cycle pulse when every channel's outputs have been updated.
- `digits_o`  out  NUM_CH x NUM_DIGITS x `score_t`: glyphs; digit 0 is least significant.
- `sat_o`  out  NUM_CH: the channel's score exceeded 10^NUM_DIGITS-1.

## Operation
- States: IDLE, SHIFT, WRITE.
- IDLE + `start_i`: snapshot all `score_i` into an internal register, set channel index c=0, load the shift register with snapshot[0], clear BCD accumulator, then go to SHIFT. `busy_o`=1.
- SHIFT: exactly SCORE_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left by 1, with the MSB of the binary shifting in. The accumulator holds ceil(SCORE_W*log10(2)) nibbles; nibbles above NUM_DIGITS are kept internally for saturation detection.
- WRITE: one cycle. If any nibble at or above index NUM_DIGITS is nonzero, set `sat_o[c]`=1 and set all `digits_o[c]` to NEIN. Otherwise clear `sat_o[c]` and map each nibble to the glyph ZERO..NEIN.
  - The write updates all digits of the channel in the same edge; outputs never show a partially converted channel.
  - Then, if c<NUM_CH-1: increment c, reload the shift register, and go to SHIFT. Otherwise go to IDLE, pulse `done_o`, and drop `busy_o`.
- `start_i` while `busy_o`=1: sets a pending flag. The in-flight sequence uses the old snapshot. On the final WRITE, if pending is set, clear it, take a fresh snapshot, and go directly to SHIFT for c=0. `busy_o` stays high and `done_o` still pulses for the completed sequence.
- `start_i` held high: treated as repeated requests, giving back-to-back conversions.
- Nibbles never exceed 9 after correction; the nibble-to-glyph map has no default case in use.
- Reset asserted mid-sequence: returns immediately to IDLE, clears pending, and restores the reset output values.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `sat_o`=0.
  - `digits_o` = ZERO in all digits; with blanking enabled, digit 0 is ZERO and higher digits are blank.
- `start_i` sampled high at edge N in IDLE gives `busy_o`=1 after edge N.
- Channel c's SHIFT edges are N+1+c·(SCORE_W+1) through N+c·(SCORE_W+1)+SCORE_W. Its WRITE edge is N+(c+1)·(SCORE_W+1).
- `done_o`=1 and `busy_o`=0 after edge N+NUM_CH·(SCORE_W+1), for one cycle. With defaults this is N+16.
- A new `start_i` is accepted in IDLE on the cycle `done_o` is high.
- `score_i` is sampled only at the snapshot edge; changes during a sequence are ignored.

## Configuration
- `SCORE_BLANK_LZ_EN` defined: leading-zero digits above digit 0 output the all-zeros glyph `'0` (blank). Digit 0 always shows ZERO when the score is 0. Saturated channels are unaffected and show all NEIN.
- Not defined: every digit always shows its glyph, including leading ZERO.

## Test plan
- Reset with `rst_ni`=0 asserted asynchronously mid-SHIFT -> `busy_o`, `done_o` and `sat_o` are 0 immediately, `digits_o` are at reset values, and the next `start_i` runs a clean full sequence.
- Defaults; scores {player=7, enemy=42}; one `start_i` at edge N -> `digits_o[0]`={SEVEN, ZERO} (ZERO blank with the macro), `digits_o[1]`={TWO, FOUR}; `done_o` after edge N+16 only; `sat_o`=0.
- Scores {99, 100}, NUM_DIGITS=2 -> channel 0 = {NEIN, NEIN}, `sat_o[0]`=0; channel 1 = {NEIN, NEIN}, `sat_o[1]`=1. Then {5, 0} -> `sat_o[1]` clears.
- `start_i` at edge N and again at N+5 with the score changed from 3 to 4 in between -> the first `done_o` shows 3, `busy_o` stays high, and the second `done_o` at N+32 shows 4.
- `score_i` toggled every cycle during SHIFT -> outputs reflect the value present at the snapshot edge.
- Sweep 0..127 on both channels, with and without `SCORE_BLANK_LZ_EN` -> every digit matches a decimal model, and blanking applies only to leading zeros.
